// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the three-port RAM arbiter.
//   - default address / data widths
//   - requester port indices (loader, CPU data, CPU fetch)
//   - arbiter FSM state encoding
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  localparam int LOADER = 0;
  localparam int DATA   = 1;
  localparam int FETCH  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between three requesters, the arbiter and a single-port RAM.
//   requester side : i_req/i_we per port, i_addrN/i_wdataN, o_ack, o_rdata, o_grant, o_busy
//   RAM side       : o_mem_en/o_mem_we/o_mem_addr/o_mem_wdata out, i_mem_rdata in
//                    (RAM read data arrives one cycle after o_mem_en)
// Modports: slave = arbiter view, master = environment (requesters + RAM) view.
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic [2:0]        i_req;
  logic [2:0]        i_we;
  logic [ADDR_W-1:0] i_addr0, i_addr1, i_addr2;
  logic [DATA_W-1:0] i_wdata0, i_wdata1, i_wdata2;
  logic [2:0]        o_ack;
  logic [DATA_W-1:0] o_rdata;
  logic [2:0]        o_grant;
  logic              o_busy;
  logic              o_mem_en;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;

  modport slave (
    input  i_req, i_we, i_addr0, i_addr1, i_addr2, i_wdata0, i_wdata1, i_wdata2, i_mem_rdata,
    output o_ack, o_rdata, o_grant, o_busy, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_req, i_we, i_addr0, i_addr1, i_addr2, i_wdata0, i_wdata1, i_wdata2, i_mem_rdata,
    input  o_ack, o_rdata, o_grant, o_busy, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational winner selection.
//   req[2:0]  in  request vector (bit 0 loader, 1 CPU data, 2 CPU fetch)
//   last      in  1 = fetch port was the most recent data/fetch grant
//   pick[2:0] out one-hot winner, 0 when nothing requests
// Loader always wins; data/fetch share by alternating on a tie.
module arb_pick import mem_arbiter_pkg::*; (
  input  logic [2:0] req,
  input  logic       last,
  output logic [2:0] pick
);

  always_comb begin
    pick = '0;
    if (req[LOADER])
      pick[LOADER] = 1'b1;
    else if (req[DATA] && req[FETCH]) begin
      // tie: the side that did not win last time goes now
      if (last) pick[DATA]  = 1'b1;
      else      pick[FETCH] = 1'b1;
    end
    else if (req[DATA])
      pick[DATA] = 1'b1;
    else if (req[FETCH])
      pick[FETCH] = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM among three requesters.
//   i_clk  system clock (rising edge)
//   i_rst  synchronous active-high reset
//   bus    mem_arbiter_if.slave -- requester ports and RAM port
// Each access runs IDLE -> ACCESS -> ACK. The winner's we/addr/wdata are
// captured on the IDLE->ACCESS edge so requester changes after that are
// ignored. RAM strobes are driven only in ACCESS; the RAM answers one cycle
// later, which is exactly the ACK cycle where the data is forwarded.
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mem_arbiter_if.slave  bus
);

  arb_state_t        state_q, state_d;
  logic              last_q;       // 1 = fetch port won the last data/fetch grant
  logic [2:0]        lat_sel;      // one-hot owner of the current access
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic [2:0]        pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              take;

  arb_pick u_pick (
    .req  (bus.i_req),
    .last (last_q),
    .pick (pick)
  );

  // request mux steered by the one-hot pick
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (pick[LOADER]) begin
      sel_we    = bus.i_we[LOADER];
      sel_addr  = bus.i_addr0;
      sel_wdata = bus.i_wdata0;
    end
    else if (pick[DATA]) begin
      sel_we    = bus.i_we[DATA];
      sel_addr  = bus.i_addr1;
      sel_wdata = bus.i_wdata1;
    end
    else if (pick[FETCH]) begin
      sel_we    = bus.i_we[FETCH];
      sel_addr  = bus.i_addr2;
      sel_wdata = bus.i_wdata2;
    end
  end

  assign take = (state_q == IDLE) && (bus.i_req != 3'b000);

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_req != 3'b000) state_d = ACCESS;
      ACCESS:  state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // captured request and round-robin history
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_q    <= 1'b1;   // pretend fetch went last so data wins the first tie
      lat_sel   <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end
    else if (take) begin
      lat_sel   <= pick;
      lat_we    <= sel_we;
      lat_addr  <= sel_addr;
      lat_wdata <= sel_wdata;
      // loader grants leave the data/fetch history untouched
      if (pick[DATA] || pick[FETCH]) last_q <= pick[FETCH];
    end
  end

  // outputs decoded from state
  always_comb begin
    bus.o_ack       = '0;
    bus.o_rdata     = '0;
    bus.o_grant     = '0;
    bus.o_busy      = 1'b0;
    bus.o_mem_en    = 1'b0;
    bus.o_mem_we    = 1'b0;
    bus.o_mem_addr  = '0;
    bus.o_mem_wdata = '0;
    case (state_q)
      ACCESS: begin
        bus.o_busy      = 1'b1;
        bus.o_grant     = lat_sel;
        bus.o_mem_en    = 1'b1;
        bus.o_mem_we    = lat_we;
        bus.o_mem_addr  = lat_addr;
        bus.o_mem_wdata = lat_wdata;
      end
      ACK: begin
        bus.o_busy  = 1'b1;
        bus.o_ack   = lat_sel;
        bus.o_rdata = lat_we ? '0 : bus.i_mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by three randomized
// requesters checked through per-port expected-response queues and a
// cycle monitor that applies the priority / alternation rules.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus();
  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  logic [2:0] t_req = '0;
  logic [2:0] t_we  = '0;
  logic [7:0] t_addr [3];
  logic [7:0] t_wdata[3];

  assign bus.i_req    = t_req;
  assign bus.i_we     = t_we;
  assign bus.i_addr0  = t_addr[0];
  assign bus.i_addr1  = t_addr[1];
  assign bus.i_addr2  = t_addr[2];
  assign bus.i_wdata0 = t_wdata[0];
  assign bus.i_wdata1 = t_wdata[1];
  assign bus.i_wdata2 = t_wdata[2];

  // RAM with one-cycle registered read
  logic [7:0] ram[256];
  logic [7:0] ref_mem[256];
  logic [7:0] mem_rdata = '0;
  assign bus.i_mem_rdata = mem_rdata;
  always @(posedge clk)
    if (bus.o_mem_en) begin
      if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_wdata;
      else              mem_rdata <= ram[bus.o_mem_addr];
    end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- expected-response queues ----------------
  txn_t q0[$], q1[$], q2[$];

  function automatic void q_push(input int p, input txn_t t);
    case (p)
      0: q0.push_back(t);
      1: q1.push_back(t);
      default: q2.push_back(t);
    endcase
  endfunction

  function automatic int q_size(input int p);
    case (p)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic txn_t q_pop(input int p);
    case (p)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic txn_t q_front(input int p);
    case (p)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  // ---------------- reference arbitration rule ----------------
  function automatic int winner(input logic [2:0] r, input int last);
    if (r[0]) return 0;
    if (r[1] && r[2]) return (last == 2) ? 1 : 2;
    return r[1] ? 1 : 2;
  endfunction

  // Monitor: a decision taken at cycle d shows as grant at d+1, ack at d+2,
  // and the arbiter may decide again at d+3.
  logic       mon_en = 1'b0;
  int         mcyc, mdec, mpick, mlast;
  logic [2:0] eg, ea;
  txn_t       mt;

  always @(negedge clk)
    if (mon_en) begin
      eg = (mcyc == mdec + 1) ? 3'(1 << mpick) : 3'b000;
      ea = (mcyc == mdec + 2) ? 3'(1 << mpick) : 3'b000;
      check("mon_grant", bus.o_grant, eg);
      check("mon_ack", bus.o_ack, ea);
      check("mon_mem_en", bus.o_mem_en, eg != 3'b000);
      check("mon_busy", bus.o_busy, (eg | ea) != 3'b000);
      if (eg != 3'b000) begin
        if (q_size(mpick) == 0) begin
          n_vec++; n_err++;
          $display("FAIL mon_grant_unexpected: port %0d granted with nothing pending", mpick);
        end
        else begin
          mt = q_front(mpick);
          check("mon_mem_we", bus.o_mem_we, mt.we);
          check("mon_mem_addr", bus.o_mem_addr, mt.addr);
          if (mt.we) check("mon_mem_wdata", bus.o_mem_wdata, mt.wdata);
        end
      end
      else check("mon_mem_we_idle", bus.o_mem_we, 1'b0);
      if (ea != 3'b000 && q_size(mpick) != 0) begin
        mt = q_pop(mpick);
        check("mon_rdata", bus.o_rdata, mt.rdata);
      end
      if (mcyc >= mdec + 3 && bus.i_req != 3'b000) begin
        mpick = winner(bus.i_req, mlast);
        mdec  = mcyc;
        if (mpick != 0) mlast = mpick;
      end
      mcyc++;
    end

  // ---------------- randomized requester ----------------
  task automatic requester(input int p, input int n);
    txn_t t;
    bit   done;
    for (int k = 0; k < n; k++) begin
      int gap = $urandom_range(0, 3);
      if (gap > 0) begin
        t_req[p] = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      t.we    = 1'($urandom_range(0, 1));
      t.addr  = (p == 0) ? 8'($urandom_range(0, 63)) :
                (p == 1) ? 8'(64 + $urandom_range(0, 63)) : 8'(128 + $urandom_range(0, 127));
      t.wdata = 8'($urandom);
      t.rdata = t.we ? 8'h00 : ref_mem[t.addr];
      if (t.we) ref_mem[t.addr] = t.wdata;
      q_push(p, t);
      t_we[p] = t.we; t_addr[p] = t.addr; t_wdata[p] = t.wdata;
      t_req[p] = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 1000 && !done; c++) begin
        @(negedge clk);
        // once granted the arbiter must ignore the requester's inputs
        if (bus.o_grant[p] && $urandom_range(0, 1) == 1) begin
          t_addr[p] = 8'($urandom); t_wdata[p] = 8'($urandom); t_we[p] = ~t_we[p];
        end
        if (bus.o_ack[p]) done = 1'b1;
      end
      if (!done) begin
        n_vec++; n_err++;
        $display("FAIL req_timeout: port %0d got no ack", p);
        t_req[p] = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    t_req[p] = 1'b0;
  endtask

  // ---------------- directed helpers ----------------
  task automatic wait_ack(output int p, output logic [7:0] rd, output int c);
    p = -1; rd = '0; c = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.o_ack != 3'b000) begin
        p  = (bus.o_ack == 3'b001) ? 0 : (bus.o_ack == 3'b010) ? 1 : (bus.o_ack == 3'b100) ? 2 : 9;
        rd = bus.o_rdata;
        c  = cyc;
        return;
      end
    end
    n_vec++; n_err++;
    $display("FAIL ack_timeout: no o_ack within 50 cycles");
  endtask

  // called at posedge+1 with the arbiter idle
  task automatic do_txn(input int p, input logic we, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp, input bit scramble);
    t_we[p] = we; t_addr[p] = a; t_wdata[p] = d;
    t_req = 3'(1 << p);
    @(posedge clk); #1;
    if (scramble) begin
      t_addr[p] = a + 8'd1; t_wdata[p] = ~d; t_we[p] = ~we;
    end
    @(negedge clk);
    check("acc_grant", bus.o_grant, 3'(1 << p));
    check("acc_mem_en", bus.o_mem_en, 1'b1);
    check("acc_mem_we", bus.o_mem_we, we);
    check("acc_mem_addr", bus.o_mem_addr, a);
    if (we) check("acc_mem_wdata", bus.o_mem_wdata, d);
    check("acc_ack_low", bus.o_ack, 3'b000);
    @(negedge clk);
    check("ack_pulse", bus.o_ack, 3'(1 << p));
    check("ack_rdata", bus.o_rdata, exp);
    check("ack_mem_en_low", bus.o_mem_en, 1'b0);
    check("ack_grant_low", bus.o_grant, 3'b000);
    check("ack_busy", bus.o_busy, 1'b1);
    @(posedge clk); #1;
    t_req = 3'b000;
    @(negedge clk);
    check("post_ack_low", bus.o_ack, 3'b000);
    check("post_busy_low", bus.o_busy, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         p, c, prev;
    logic [7:0] rd;
    int         ord[4];

    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
    ram[8'h11] = 8'h5A; ref_mem[8'h11] = 8'h5A;
    for (int i = 0; i < 3; i++) begin t_addr[i] = '0; t_wdata[i] = '0; end

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", bus.o_ack, 3'b000);
    check("rst_grant", bus.o_grant, 3'b000);
    check("rst_busy", bus.o_busy, 1'b0);
    check("rst_mem_en", bus.o_mem_en, 1'b0);
    check("rst_mem_we", bus.o_mem_we, 1'b0);
    check("rst_mem_addr", bus.o_mem_addr, 8'h00);
    check("rst_mem_wdata", bus.o_mem_wdata, 8'h00);
    check("rst_rdata", bus.o_rdata, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;

    // single read with inputs disturbed during ACCESS; then write + readback
    do_txn(DATA, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b1);
    do_txn(LOADER, 1'b1, 8'h20, 8'h3C, 8'h00, 1'b0);
    ref_mem[8'h20] = 8'h3C;
    do_txn(DATA, 1'b0, 8'h20, 8'h00, 8'h3C, 1'b0);

    // contention: loader holds, then data/fetch alternate (data went last)
    t_we = 3'b000;
    t_addr[0] = 8'h30; t_addr[1] = 8'h40; t_addr[2] = 8'h80;
    t_req = 3'b111;
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      wait_ack(p, rd, c);
      check("cont_loader_first", p, 0);
      check("cont_loader_rdata", rd, ref_mem[8'h30]);
      if (i > 0) check("cont_gap", c - prev, 3);
      prev = c;
    end
    @(posedge clk); #1;
    t_req[0] = 1'b0;
    ord = '{2, 1, 2, 1};
    for (int i = 0; i < 4; i++) begin
      wait_ack(p, rd, c);
      check("cont_rr_order", p, ord[i]);
      check("cont_rr_gap", c - prev, 3);
      prev = c;
    end
    @(posedge clk); #1;
    t_req = 3'b000;
    @(posedge clk); #1;

    // post-reset tie goes to data first
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    t_addr[1] = 8'h41; t_addr[2] = 8'h81;
    t_req = 3'b110;
    wait_ack(p, rd, c);
    check("tie_first_data", p, 1);
    check("tie_first_rdata", rd, ref_mem[8'h41]);
    wait_ack(p, rd, c);
    check("tie_second_fetch", p, 2);
    check("tie_second_rdata", rd, ref_mem[8'h81]);
    @(posedge clk); #1;
    t_req = 3'b000;
    @(posedge clk); #1;

    // reset during ACCESS aborts; held request re-granted afterwards
    t_addr[2] = 8'h82;
    t_req = 3'b100;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_access", bus.o_grant, 3'b100);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_no_ack", bus.o_ack, 3'b000);
    check("abort_mem_en", bus.o_mem_en, 1'b0);
    check("abort_grant", bus.o_grant, 3'b000);
    check("abort_busy", bus.o_busy, 1'b0);
    wait_ack(p, rd, c);
    check("abort_regrant", p, 2);
    check("abort_regrant_rdata", rd, ref_mem[8'h82]);
    @(posedge clk); #1;
    t_req = 3'b000;
    @(posedge clk); #1;

    // a request dropped before it is granted is forgotten
    t_addr[0] = 8'h31;
    t_req = 3'b001;
    @(posedge clk); #1;
    t_addr[1] = 8'h42; t_req[1] = 1'b1;
    @(posedge clk); #1;
    t_req = 3'b000;
    @(negedge clk);
    check("drop_loader_ack", bus.o_ack, 3'b001);
    repeat (6) begin
      @(negedge clk);
      check("drop_no_ack", bus.o_ack, 3'b000);
      check("drop_no_grant", bus.o_grant, 3'b000);
    end
    @(posedge clk); #1;

    // randomized phase
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    mcyc = 0; mdec = -10; mpick = 0; mlast = 2;
    mon_en = 1'b1;
    fork
      requester(0, 40);
      requester(1, 40);
      requester(2, 40);
    join
    repeat (5) @(posedge clk);
    mon_en = 1'b0;
    for (int i = 0; i < 3; i++) check("queue_drained", q_size(i), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, RAM address width.
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 The block SHALL have a single clock domain; reset is synchronous and active-high.
REQ-004 i_clk  in  1  system clock, all logic rising-edge.
REQ-005 i_rst  in  1  synchronous active-high reset.
REQ-006 i_req[2:0]  in  3  per-port request; port 0 = loader, 1 = CPU data, 2 = CPU fetch.
REQ-007 i_we[2:0]  in  3  per-port write enable (1 = write, 0 = read).
REQ-008 i_addr0/1/2  in  ADDR_W each  per-port address.
REQ-009 i_wdata0/1/2  in  DATA_W each  per-port write data.
REQ-010 o_ack[2:0]  out  3  one-cycle completion pulse, one-hot.
REQ-011 o_rdata  out  DATA_W  read data, valid in the o_ack cycle of a read.
REQ-012 o_grant[2:0]  out  3  one-hot owner during ACCESS state, else 0.
REQ-013 o_busy  out  1  high in ACCESS or ACK state.
REQ-014 o_mem_en, o_mem_we  out  1 each  RAM enable / write strobe.
REQ-015 o_mem_addr, o_mem_wdata  out  ADDR_W / DATA_W  RAM address / write data.
REQ-016 i_mem_rdata  in  DATA_W  RAM read data, one-cycle registered latency after o_mem_en.

Function
REQ-017 FSM states: IDLE, ACCESS, ACK; every access takes exactly 3 cycles IDLE->ACCESS->ACK->IDLE.
REQ-018 IDLE: if any i_req set, SHALL pick a winner, latch its we/addr/wdata and port index, go to ACCESS; else stay.
REQ-019 Priority: port 0 SHALL always win when requesting.
REQ-020 Ports 1 and 2 SHALL round-robin: when both request and port 0 does not, the one not granted last wins; last-grant bit updates only on grants to port 1 or 2.
REQ-021 ACCESS: o_mem_en=1, o_mem_we/addr/wdata from latched values, o_grant one-hot of winner; next state ACK.
REQ-022 ACK: o_ack[winner]=1 for exactly one cycle; o_rdata = i_mem_rdata for reads, 0 for writes; o_mem_en=0; next state IDLE.
REQ-023 Requesters SHALL hold req/we/addr/wdata stable until ack; changes during ACCESS/ACK are ignored (latched copy used).
REQ-024 A request still high in the cycle after its ack SHALL be treated as a new request.
REQ-025 Outside ACCESS, o_mem_en, o_mem_we and o_grant SHALL be 0; o_ack SHALL be 0 outside ACK.
REQ-026 Requests that drop before being granted SHALL be forgotten, with no ack.

Reset
REQ-027 i_rst sampled high SHALL force IDLE, last-grant = port 2 (so port 1 wins the first 1/2 tie), all outputs 0, latched registers 0.
REQ-028 Reset during ACCESS or ACK SHALL abort the access; no ack for it, o_mem_en low from the next cycle.
REQ-029 Reset has priority over every other event in the same cycle.

Structure
REQ-030 Shared package holds the state enum (IDLE/ACCESS/ACK), port index constants (LOADER=0, DATA=1, FETCH=2) and default widths.
REQ-031 One sub-module, arb_pick: combinational fixed-priority plus 2-way round-robin selector (inputs req[2:0], last bit; output one-hot pick). The FSM, latches and RAM mux stay in mem_arbiter.

Verification
REQ-032 Single read: req=3'b010, addr1=8'h10, RAM[10]=8'hA5 -> o_grant=010 at cycle 2, o_ack=010 and o_rdata=A5 at cycle 3.
REQ-033 Single write: req=3'b001, we0=1, addr0=8'h20, wdata0=8'h3C -> o_mem_en=o_mem_we=1 with addr 20/data 3C for one cycle, o_ack=001 next cycle; a later read of 20 returns 3C.
REQ-034 Contention: req=3'b111 held -> grant order 0,0,... while port 0 holds; drop port 0 -> grants alternate 1,2,1,2 with 3 cycles between acks.
REQ-035 Post-reset tie: reset, then req=3'b110 held -> first grant to port 1, second to port 2.
REQ-036 Reset mid-access: assert i_rst in the ACCESS cycle -> no o_ack pulse, o_mem_en=0, IDLE next; pending request re-granted after reset release.
REQ-037 Stability: change addr1 from 8'h10 to 8'h11 during ACCESS -> RAM still sees 10, ack data from address 10.
